// File: rtl/mul_div_pkg.sv
// Shared definitions for the EX-stage RV32M sequencing controller.
// Holds opcode, funct3 codes, FSM encoding and result fix-up.
package mul_div_pkg;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Unit returns remainder magnitude and zero for x%0; patch both here.
    function automatic logic [31:0] md_fixup(
        input logic [2:0]  f3,
        input logic [31:0] rs1,
        input logic [31:0] rs2,
        input logic [31:0] high,
        input logic [31:0] low
    );
        logic [31:0] r;
        r = low;
        unique case (f3)
            F3_MUL:                       r = low;
            F3_MULH, F3_MULHSU, F3_MULHU: r = high;
            F3_DIV, F3_DIVU:              r = low;
            F3_REM: begin
                if (rs2 == 32'd0)  r = rs1;
                else if (rs1[31])  r = -high;
                else               r = high;
            end
            F3_REMU:                      r = (rs2 == 32'd0) ? rs1 : high;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_div_if.sv
// Issue/writeback handshake bundle for the mul/div controller.
// master = issue+writeback side, slave = controller.
interface mul_div_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [RD_W-1:0] req_rd;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [RD_W-1:0] resp_rd;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd
    );
endinterface

// File: rtl/mul_div_ctrl.sv
// Sequencer for the iterative RV32M unit: latches one op, holds the
// unit request until done, fixes up the result and hands it back.
module mul_div_ctrl
    import mul_div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    output logic            busy_o,
    mul_div_if.slave        io,
    output logic            md_req_o,
    output logic [2:0]      md_m_d_op_o,
    output logic [6:0]      md_op_o,
    output logic [XLEN-1:0] md_rs1_o,
    output logic [XLEN-1:0] md_rs2_o,
    output logic            md_rs1_signed_o,
    output logic            md_rs2_signed_o,
    input  logic [XLEN-1:0] md_high_i,
    input  logic [XLEN-1:0] md_low_i,
    input  logic            md_ready_i,
    input  logic [5:0]      md_count_i
);

    state_e          state, state_n;
    logic            take, cap;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] rs1_q, rs2_q, res_q;
    logic [RD_W-1:0] rd_q;

    // Iteration count is debug visibility only.
    logic unused_count;
    assign unused_count = ^md_count_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            f3_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            res_q <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                f3_q  <= io.req_funct3;
                rs1_q <= io.req_rs1;
                rs2_q <= io.req_rs2;
                rd_q  <= io.req_rd;
            end
            if (cap) begin
                res_q <= md_fixup(f3_q, rs1_q, rs2_q,
                                  md_high_i, md_low_i);
            end
        end
    end

    always_comb begin
        state_n = state;
        take    = 1'b0;
        cap     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (io.req_valid && !flush_i) begin
                    state_n = ST_RUN;
                    take    = 1'b1;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_n = ST_IDLE;
                end else if (md_ready_i) begin
                    state_n = ST_RESP;
                    cap     = 1'b1;
                end
            end
            ST_RESP: begin
                if (flush_i || io.resp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Request gated by reset so the unit sees a low cycle to clear its count.
    assign md_req_o        = (state == ST_RUN) && !rst_i;
    assign md_m_d_op_o     = f3_q;
    assign md_op_o         = INST_TYPE_R_M;
    assign md_rs1_o        = rs1_q;
    assign md_rs2_o        = rs2_q;
    assign md_rs1_signed_o = (f3_q == F3_MUL) || (f3_q == F3_MULH) ||
                             (f3_q == F3_MULHSU) || (f3_q == F3_DIV) ||
                             (f3_q == F3_REM);
    assign md_rs2_signed_o = (f3_q == F3_MUL) || (f3_q == F3_MULH) ||
                             (f3_q == F3_DIV) || (f3_q == F3_REM);

    assign io.req_ready  = (state == ST_IDLE) && !flush_i;
    assign io.resp_valid = (state == ST_RESP);
    assign io.resp_data  = res_q;
    assign io.resp_rd    = rd_q;
    assign busy_o        = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed bench for mul_div_ctrl with a behavioural iterative unit.
// Expected results and latencies are hand-computed constants.
module tb_mul_div_ctrl;
    import mul_div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    mul_div_if #(.XLEN(32), .RD_W(5)) bus();

    logic        busy, md_req, md_ready, s1, s2;
    logic [2:0]  md_f3;
    logic [6:0]  md_op;
    logic [31:0] md_rs1, md_rs2, md_high, md_low;
    logic [5:0]  ucnt;

    mul_div_ctrl #(.XLEN(32), .RD_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .busy_o(busy),
        .io(bus),
        .md_req_o(md_req), .md_m_d_op_o(md_f3), .md_op_o(md_op),
        .md_rs1_o(md_rs1), .md_rs2_o(md_rs2),
        .md_rs1_signed_o(s1), .md_rs2_signed_o(s2),
        .md_high_i(md_high), .md_low_i(md_low),
        .md_ready_i(md_ready), .md_count_i(ucnt)
    );

    // Behavioural unit: 32 iterations, or done after one edge on a zero operand.
    always_ff @(posedge clk) begin
        if (!md_req) ucnt <= 6'd0;
        else if (ucnt != 6'd32) ucnt <= ucnt + 6'd1;
    end
    assign md_ready = md_req && ((ucnt == 6'd32) ||
                      ((md_rs1 == 0 || md_rs2 == 0) && ucnt != 6'd0));

    logic [63:0] ua, ub, up;
    logic [31:0] ma, mb;
    always_comb begin
        ua = {32'd0, md_rs1};
        ub = {32'd0, md_rs2};
        ma = md_rs1[31] ? -md_rs1 : md_rs1;
        mb = md_rs2[31] ? -md_rs2 : md_rs2;
        if (md_f3 == 3'd0 || md_f3 == 3'd1 || md_f3 == 3'd2)
            ua = {{32{md_rs1[31]}}, md_rs1};
        if (md_f3 == 3'd0 || md_f3 == 3'd1)
            ub = {{32{md_rs2[31]}}, md_rs2};
        up = ua * ub;
        md_high = up[63:32];
        md_low  = up[31:0];
        if (md_f3[2]) begin
            if (md_rs2 == 0) begin
                md_low  = 32'hFFFF_FFFF;
                md_high = 32'd0;
            end else if (!md_f3[0]) begin
                md_low  = (md_rs1[31] ^ md_rs2[31]) ? -(ma / mb) : ma / mb;
                md_high = ma % mb;
            end else begin
                md_low  = md_rs1 / md_rs2;
                md_high = md_rs1 % md_rs2;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        flush          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_rd     = rd;
        @(posedge clk); #1;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp,
                          input int lat, input logic e1, input logic e2,
                          input int hold);
        int n;
        issue(f3, a, b, rd);
        chk1({tag, " md_req"}, md_req, 1'b1);
        chk({tag, " md_rs2"}, md_rs2, b);
        chk({tag, " f3"}, 32'(md_f3), 32'(f3));
        chk({tag, " sgn"}, 32'({s1, s2}), 32'({e1, e2}));
        n = 0;
        while (!bus.resp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " lat"}, 32'(n), 32'(lat));
        chk({tag, " data"}, bus.resp_data, exp);
        chk({tag, " rd"}, 32'(bus.resp_rd), 32'(rd));
        chk1({tag, " req_off"}, md_req, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold data"}, bus.resp_data, exp);
            chk({tag, " hold rd"}, 32'(bus.resp_rd), 32'(rd));
            chk1({tag, " hold rdy"}, bus.req_ready, 1'b0);
            chk1({tag, " hold busy"}, busy, 1'b1);
            chk1({tag, " hold vld"}, bus.resp_valid, 1'b1);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk1({tag, " done vld"}, bus.resp_valid, 1'b0);
        chk1({tag, " done busy"}, busy, 1'b0);
        chk1({tag, " done rdy"}, bus.req_ready, 1'b1);
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_rs1    = 32'd0;
        bus.req_rs2    = 32'd0;
        bus.req_rd     = 5'd0;
        bus.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk1("rst md_req", md_req, 1'b0);
        chk1("rst resp_valid", bus.resp_valid, 1'b0);
        chk1("rst busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("rst req_ready", bus.req_ready, 1'b1);
        chk("rst data", bus.resp_data, 32'd0);
        chk("rst rd", 32'(bus.resp_rd), 32'd0);
        chk("rst rs1", md_rs1, 32'd0);
        chk("rst f3", 32'(md_f3), 32'd0);
        chk("md_op", 32'(md_op), 32'h33);

        run_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1,
               32'hFFFF_FFEB, 33, 1'b1, 1'b1, 0);
        run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
               32'hFFFF_FFFE, 33, 1'b0, 1'b0, 0);
        run_op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd3,
               32'h4000_0000, 33, 1'b1, 1'b1, 0);
        run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4,
               32'hFFFF_FFFF, 33, 1'b1, 1'b0, 0);
        run_op("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5,
               32'hFFFF_FFFD, 33, 1'b1, 1'b1, 0);
        run_op("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6,
               32'hFFFF_FFFF, 33, 1'b1, 1'b1, 0);
        run_op("remu", F3_REMU, 32'd7, 32'd2, 5'd7,
               32'd1, 33, 1'b0, 1'b0, 0);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,
               32'h8000_0000, 33, 1'b1, 1'b1, 0);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
               32'd0, 33, 1'b1, 1'b1, 0);
        run_op("divu0", F3_DIVU, 32'd5, 32'd0, 5'd10,
               32'hFFFF_FFFF, 2, 1'b0, 1'b0, 0);
        run_op("rem0", F3_REM, 32'd5, 32'd0, 5'd11,
               32'd5, 2, 1'b1, 1'b1, 0);
        run_op("mul0", F3_MUL, 32'd0, 32'd9, 5'd12,
               32'd0, 2, 1'b1, 1'b1, 0);
        run_op("bp", F3_DIVU, 32'd100, 32'd7, 5'd13,
               32'd14, 33, 1'b0, 1'b0, 5);

        @(negedge clk);
        flush          = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F3_MUL;
        bus.req_rs1    = 32'd2;
        bus.req_rs2    = 32'd2;
        #1;
        chk1("idle flush rdy", bus.req_ready, 1'b0);
        @(posedge clk); #1;
        chk1("idle flush busy", busy, 1'b0);
        chk1("idle flush req", md_req, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        flush         = 1'b0;

        issue(F3_MUL, 32'd3, 32'd5, 5'd14);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        chk1("flush busy", busy, 1'b0);
        chk1("flush md_req", md_req, 1'b0);
        chk1("flush vld", bus.resp_valid, 1'b0);
        run_op("post_flush", F3_MUL, 32'd6, 32'd7, 5'd15,
               32'd42, 33, 1'b1, 1'b1, 0);

        issue(F3_MULHU, 32'd3, 32'd5, 5'd16);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("rst_run md_req", md_req, 1'b0);
        @(posedge clk); #1;
        chk1("rst_run busy", busy, 1'b0);
        chk1("rst_run vld", bus.resp_valid, 1'b0);
        chk("rst_run data", bus.resp_data, 32'd0);
        chk("rst_run rs1", md_rs1, 32'd0);
        chk("rst_run f3", 32'(md_f3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", F3_REMU, 32'd7, 32'd2, 5'd17,
               32'd1, 33, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
